// File: rtl/traffic_phase_scheduler.sv
// Four-phase traffic-light sequencer with countdown, LED pattern and a shared,
// round-robin arbitrated extension budget per PASS phase.
module traffic_phase_scheduler #(
  parameter logic [7:0] T_HW_PASS  = 8'd9,
  parameter logic [7:0] T_HW_WARN  = 8'd3,
  parameter logic [7:0] T_CR_PASS  = 8'd6,
  parameter logic [7:0] T_CR_WARN  = 8'd3,
  parameter logic [7:0] EXT_STEP   = 8'd30,
  parameter logic [1:0] MAX_EXT    = 2'd3,
  parameter logic [7:0] REMAIN_MAX = 8'd99
) (
  input  logic       Sys_CLK,
  input  logic       Sys_RST,
  input  logic       tick,
  input  logic [1:0] req,
  output logic [7:0] remain,
  output logic [1:0] phase,
  output logic [3:0] LED,
  output logic       phase_done,
  output logic [1:0] ext_grant,
  output logic       ext_deny,
  output logic [1:0] ext_cnt
);

  typedef enum logic [1:0] {
    StHwPass = 2'd0,
    StHwWarn = 2'd1,
    StCrPass = 2'd2,
    StCrWarn = 2'd3
  } phase_e;

  phase_e     r_phase, w_phase_d, w_phase_succ;
  logic [7:0] r_remain, w_remain_d, w_dur_succ;
  logic [3:0] r_led, w_led_d;
  logic       r_phase_done, w_phase_done_d;
  logic [1:0] r_grant, w_grant_d;
  logic       r_deny, w_deny_d;
  logic [1:0] r_ext_cnt, w_ext_cnt_d;
  logic [1:0] r_pend, w_pend_d;
  logic [1:0] r_req_q;
  logic       r_rr_ptr, w_rr_ptr_d;

  logic [1:0] w_rise;
  logic       w_is_pass;
  logic       w_advance;
  logic [7:0] w_rem_dec;
  logic [8:0] w_ext_sum;
  logic [7:0] w_rem_ext;
  logic       w_gidx;

  function automatic logic [3:0] led_of(phase_e p);
    logic [3:0] v;
    v = 4'b1001;
    unique case (p)
      StHwPass: v = 4'b0011;
      StHwWarn: v = 4'b0110;
      StCrPass: v = 4'b1001;
      StCrWarn: v = 4'b1100;
    endcase
    return v;
  endfunction

  always_comb begin
    w_phase_succ = StCrPass;
    w_dur_succ   = T_CR_PASS;
    unique case (r_phase)
      StHwPass: begin w_phase_succ = StHwWarn; w_dur_succ = T_HW_WARN; end
      StHwWarn: begin w_phase_succ = StCrPass; w_dur_succ = T_CR_PASS; end
      StCrPass: begin w_phase_succ = StCrWarn; w_dur_succ = T_CR_WARN; end
      StCrWarn: begin w_phase_succ = StHwPass; w_dur_succ = T_HW_PASS; end
    endcase
  end

  always_comb begin
    w_rise    = req & ~r_req_q;
    w_is_pass = (r_phase == StHwPass) || (r_phase == StCrPass);
    w_advance = tick && (r_remain == 8'd1);
    w_rem_dec = tick ? (r_remain - 8'd1) : r_remain;
    w_ext_sum = {1'b0, w_rem_dec} + {1'b0, EXT_STEP};
    w_rem_ext = (w_ext_sum > {1'b0, REMAIN_MAX}) ? REMAIN_MAX : w_ext_sum[7:0];
    // With both pending, the requester not granted last wins.
    w_gidx    = (r_pend == 2'b11) ? ~r_rr_ptr : r_pend[1];

    w_phase_d      = r_phase;
    w_remain_d     = w_rem_dec;
    w_led_d        = r_led;
    w_phase_done_d = 1'b0;
    w_grant_d      = 2'b00;
    w_deny_d       = 1'b0;
    w_ext_cnt_d    = r_ext_cnt;
    w_pend_d       = r_pend | (w_is_pass ? w_rise : 2'b00);
    w_rr_ptr_d     = r_rr_ptr;

    if (w_advance) begin
      w_phase_d      = w_phase_succ;
      w_remain_d     = w_dur_succ;
      w_led_d        = led_of(w_phase_succ);
      w_phase_done_d = 1'b1;
      w_ext_cnt_d    = 2'd0;
      w_pend_d       = 2'b00;
    end else if (r_pend != 2'b00) begin
      if (r_ext_cnt < MAX_EXT) begin
        w_grant_d          = w_gidx ? 2'b10 : 2'b01;
        w_ext_cnt_d        = r_ext_cnt + 2'd1;
        w_pend_d[w_gidx]   = 1'b0;
        w_remain_d         = w_rem_ext;
        w_rr_ptr_d         = w_gidx;
      end else begin
        w_deny_d = 1'b1;
        w_pend_d = w_is_pass ? w_rise : 2'b00;
      end
    end
  end

  always_ff @(posedge Sys_CLK or posedge Sys_RST) begin
    if (Sys_RST) begin
      r_phase      <= StCrPass;
      r_remain     <= T_CR_PASS;
      r_led        <= 4'b1001;
      r_phase_done <= 1'b0;
      r_grant      <= 2'b00;
      r_deny       <= 1'b0;
      r_ext_cnt    <= 2'd0;
      r_pend       <= 2'b00;
      r_req_q      <= 2'b00;
      r_rr_ptr     <= 1'b1;
    end else begin
      r_phase      <= w_phase_d;
      r_remain     <= w_remain_d;
      r_led        <= w_led_d;
      r_phase_done <= w_phase_done_d;
      r_grant      <= w_grant_d;
      r_deny       <= w_deny_d;
      r_ext_cnt    <= w_ext_cnt_d;
      r_pend       <= w_pend_d;
      r_req_q      <= req;
      r_rr_ptr     <= w_rr_ptr_d;
    end
  end

  assign remain     = r_remain;
  assign phase      = r_phase;
  assign LED        = r_led;
  assign phase_done = r_phase_done;
  assign ext_grant  = r_grant;
  assign ext_deny   = r_deny;
  assign ext_cnt    = r_ext_cnt;

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Scenario bench for traffic_phase_scheduler: expected snapshots are queued as stimulus
// is driven and compared against samples taken after each clock edge.
module tb_traffic_phase_scheduler;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic [1:0] req  = 2'b00;
  logic [7:0] remain;
  logic [1:0] phase;
  logic [3:0] LED;
  logic       phase_done;
  logic [1:0] ext_grant;
  logic       ext_deny;
  logic [1:0] ext_cnt;

  traffic_phase_scheduler dut (
    .Sys_CLK    (clk),
    .Sys_RST    (rst),
    .tick       (tick),
    .req        (req),
    .remain     (remain),
    .phase      (phase),
    .LED        (LED),
    .phase_done (phase_done),
    .ext_grant  (ext_grant),
    .ext_deny   (ext_deny),
    .ext_cnt    (ext_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [19:0] v;
  } ent_t;

  ent_t        exp_q[$];
  logic [19:0] obs_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [3:0] led_of(logic [1:0] ph);
    case (ph)
      2'd0:    return 4'b0011;
      2'd1:    return 4'b0110;
      2'd2:    return 4'b1001;
      default: return 4'b1100;
    endcase
  endfunction

  function automatic int dur(int ph);
    case (ph)
      0:       return 9;
      1:       return 3;
      2:       return 6;
      default: return 3;
    endcase
  endfunction

  // Layout: {phase, remain, LED, phase_done, ext_grant, ext_deny, ext_cnt}
  function automatic logic [19:0] snap(int ph, int rem, bit pd, logic [1:0] gr, bit dn,
                                       int cnt);
    logic [1:0] p;
    logic [7:0] r;
    logic [1:0] c;
    p = ph[1:0];
    r = rem[7:0];
    c = cnt[1:0];
    return {p, r, led_of(p), pd, gr, dn, c};
  endfunction

  function automatic logic [19:0] obs();
    return {phase, remain, LED, phase_done, ext_grant, ext_deny, ext_cnt};
  endfunction

  function automatic void push_exp(string tag, logic [19:0] v);
    ent_t x;
    x.tag = tag;
    x.v   = v;
    exp_q.push_back(x);
  endfunction

  task automatic step(input logic t, input logic [1:0] r, input bit chk);
    @(negedge clk);
    tick = t;
    req  = r;
    @(posedge clk);
    #1;
    if (chk) obs_q.push_back(obs());
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst  = 1'b1;
    tick = 1'b0;
    req  = 2'b00;
    @(negedge clk);
    rst  = 1'b0;
  endtask

  task automatic goto_hw_pass();
    reset_pulse();
    for (int i = 0; i < 9; i++) step(1'b1, 2'b00, 1'b0);
  endtask

  task automatic test_reset();
    ent_t e;
    logic [19:0] o;
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; req = 2'b00;
    #1;
    push_exp("rst_async", snap(2, 6, 0, 2'b00, 0, 0));
    obs_q.push_back(obs());
    @(posedge clk); #1;
    push_exp("rst_hold", snap(2, 6, 0, 2'b00, 0, 0));
    obs_q.push_back(obs());
    @(negedge clk);
    rst = 1'b0;
    push_exp("rst_idle", snap(2, 6, 0, 2'b00, 0, 0)); step(1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_cycle();
    ent_t e;
    logic [19:0] o;
    int ph = 2;
    int nph;
    for (int s = 0; s < 4; s++) begin
      for (int k = dur(ph) - 1; k >= 1; k--) begin
        push_exp($sformatf("cyc_ph%0d_rem%0d", ph, k), snap(ph, k, 0, 2'b00, 0, 0));
        step(1'b1, 2'b00, 1'b1);
      end
      nph = (ph + 1) % 4;
      push_exp($sformatf("cyc_enter_ph%0d", nph), snap(nph, dur(nph), 1, 2'b00, 0, 0));
      step(1'b1, 2'b00, 1'b1);
      ph = nph;
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_single_grant();
    ent_t e;
    logic [19:0] o;
    push_exp("sg_rem5",  snap(2, 5, 0, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("sg_pend",  snap(2, 5, 0, 2'b00, 0, 0)); step(1'b0, 2'b01, 1'b1);
    push_exp("sg_grant", snap(2, 35, 0, 2'b01, 0, 1)); step(1'b0, 2'b01, 1'b1);
    push_exp("sg_held",  snap(2, 35, 0, 2'b00, 0, 1)); step(1'b0, 2'b01, 1'b1);
    push_exp("sg_quiet", snap(2, 35, 0, 2'b00, 0, 1)); step(1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t e;
    logic [19:0] o;
    goto_hw_pass();
    push_exp("bb_pend",   snap(0, 9, 0, 2'b00, 0, 0));  step(1'b0, 2'b11, 1'b1);
    push_exp("bb_g0",     snap(0, 39, 0, 2'b01, 0, 1)); step(1'b0, 2'b11, 1'b1);
    push_exp("bb_g1",     snap(0, 69, 0, 2'b10, 0, 2)); step(1'b0, 2'b11, 1'b1);
    push_exp("bb_idle",   snap(0, 69, 0, 2'b00, 0, 2)); step(1'b0, 2'b00, 1'b1);
    push_exp("bb_pend2",  snap(0, 69, 0, 2'b00, 0, 2)); step(1'b0, 2'b11, 1'b1);
    push_exp("bb_rr_g0",  snap(0, 99, 0, 2'b01, 0, 3)); step(1'b0, 2'b11, 1'b1);
    push_exp("bb_deny",   snap(0, 99, 0, 2'b00, 1, 3)); step(1'b0, 2'b11, 1'b1);
    push_exp("bb_after",  snap(0, 99, 0, 2'b00, 0, 3)); step(1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_budget();
    ent_t e;
    logic [19:0] o;
    int rem = 6;
    reset_pulse();
    for (int i = 0; i < 4; i++) begin
      push_exp($sformatf("bud_pend%0d", i), snap(2, rem, 0, 2'b00, 0, i));
      step(1'b0, 2'b10, 1'b1);
      if (i == 0) begin
        // tick in the grant cycle: extension applies to the decremented value
        rem = rem - 1 + 30;
        push_exp("bud_grant0_tick", snap(2, rem, 0, 2'b10, 0, 1));
        step(1'b1, 2'b10, 1'b1);
      end else if (i < 3) begin
        rem = rem + 30;
        push_exp($sformatf("bud_grant%0d", i), snap(2, rem, 0, 2'b10, 0, i + 1));
        step(1'b0, 2'b10, 1'b1);
      end else begin
        push_exp("bud_deny", snap(2, rem, 0, 2'b00, 1, 3));
        step(1'b0, 2'b10, 1'b1);
      end
      push_exp($sformatf("bud_quiet%0d", i), snap(2, rem, 0, 2'b00, 0, (i < 3) ? i + 1 : 3));
      step(1'b0, 2'b00, 1'b1);
    end
    for (int i = 0; i < rem - 1; i++) step(1'b1, 2'b00, 1'b0);
    push_exp("bud_to_crwarn", snap(3, 3, 1, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b00, 1'b0);
    push_exp("bud_to_hwpass", snap(0, 9, 1, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_warn_collide();
    ent_t e;
    logic [19:0] o;
    reset_pulse();
    for (int i = 0; i < 5; i++) step(1'b1, 2'b00, 1'b0);
    push_exp("wc_crwarn", snap(3, 3, 1, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("wc_rise0",  snap(3, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b01, 1'b1);
    push_exp("wc_hold0",  snap(3, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b01, 1'b1);
    push_exp("wc_rise1",  snap(3, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b11, 1'b1);
    push_exp("wc_drop",   snap(3, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b00, 1'b1);
    push_exp("wc_rem2",   snap(3, 2, 0, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("wc_rem1",   snap(3, 1, 0, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("wc_hwpass", snap(0, 9, 1, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 2'b00, 1'b0);
    push_exp("wc_last",   snap(0, 1, 0, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("wc_pend",   snap(0, 1, 0, 2'b00, 0, 0)); step(1'b0, 2'b10, 1'b1);
    push_exp("wc_adv",    snap(1, 3, 1, 2'b00, 0, 0)); step(1'b1, 2'b10, 1'b1);
    push_exp("wc_nogr",   snap(1, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b10, 1'b1);
    push_exp("wc_nogr2",  snap(1, 3, 0, 2'b00, 0, 0)); step(1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    ent_t e;
    logic [19:0] o;
    goto_hw_pass();
    push_exp("rm_rem8", snap(0, 8, 0, 2'b00, 0, 0)); step(1'b1, 2'b00, 1'b1);
    push_exp("rm_pend", snap(0, 8, 0, 2'b00, 0, 0)); step(1'b0, 2'b01, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    push_exp("rm_async", snap(2, 6, 0, 2'b00, 0, 0));
    obs_q.push_back(obs());
    @(posedge clk); #1;
    push_exp("rm_hold", snap(2, 6, 0, 2'b00, 0, 0));
    obs_q.push_back(obs());
    req = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    push_exp("rm_rel0", snap(2, 6, 0, 2'b00, 0, 0)); step(1'b0, 2'b00, 1'b1);
    push_exp("rm_rel1", snap(2, 6, 0, 2'b00, 0, 0)); step(1'b0, 2'b00, 1'b1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) $display("FAIL %s: no sample, required %h", e.tag, e.v);
      else begin
        o = obs_q.pop_front();
        if (o !== e.v) $display("FAIL %s: got %h required %h", e.tag, o, e.v);
        else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cycle();
    test_single_grant();
    test_back_to_back();
    test_budget();
    test_warn_collide();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
